// File: rtl/regfile_pkg.sv
// Shared constants and slice helper for the multi-port register file.
// The REGFILE_SCOREBOARD_EN build adds a per-register pending scoreboard.
package regfile_pkg;

   localparam int DEF_DW        = 32;
   localparam int DEF_AW        = 6;
   localparam int DEF_DEPTH     = 64;
   localparam int DEF_NUM_RD    = 2;
   localparam int REG_ZERO_ADDR = 0;
   localparam int NUM_WR        = 2;

   typedef enum logic {
      WR_P0 = 1'b0,
      WR_P1 = 1'b1
   } wr_port_e;

   // Low bit of element idx inside a flattened vector of width-bit elements.
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/write-back bus of the multi-port register file.
// Scoreboard signals exist only when REGFILE_SCOREBOARD_EN is defined.
interface reg_file_mp_if
   import regfile_pkg::*;
#(
   parameter int DW     = DEF_DW,
   parameter int AW     = DEF_AW,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int NUM_RD = DEF_NUM_RD
) ();

   logic [NUM_RD*AW-1:0] REG_rd_addr;
   logic [NUM_RD*DW-1:0] REG_rd_data;
   logic [NUM_WR-1:0]    REG_wr_en;
   logic [NUM_WR*AW-1:0] REG_wr_addr;
   logic [NUM_WR*DW-1:0] REG_wr_data;
`ifdef REGFILE_SCOREBOARD_EN
   logic                 REG_busy_set;
   logic [AW-1:0]        REG_busy_addr;
   logic [DEPTH-1:0]     REG_busy;
`endif

   modport master (
      output REG_rd_addr,
      input  REG_rd_data,
      output REG_wr_en,
      output REG_wr_addr,
      output REG_wr_data
`ifdef REGFILE_SCOREBOARD_EN
      ,
      output REG_busy_set,
      output REG_busy_addr,
      input  REG_busy
`endif
   );

   modport slave (
      input  REG_rd_addr,
      output REG_rd_data,
      input  REG_wr_en,
      input  REG_wr_addr,
      input  REG_wr_data
`ifdef REGFILE_SCOREBOARD_EN
      ,
      input  REG_busy_set,
      input  REG_busy_addr,
      output REG_busy
`endif
   );

endinterface

// File: rtl/reg_file_rd_port.sv
// One combinational read port: array mux, write bypass, zero/out-of-range
// and reset masking.
module reg_file_rd_port
   import regfile_pkg::*;
#(
   parameter int DW       = DEF_DW,
   parameter int AW       = DEF_AW,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                 i_clr_n,
   input  logic [AW-1:0]        i_rd_addr,
   input  logic [DEPTH*DW-1:0]  i_mem_flat,
   input  logic [NUM_WR-1:0]    i_wr_en,
   input  logic [NUM_WR*AW-1:0] i_wr_addr,
   input  logic [NUM_WR*DW-1:0] i_wr_data,
   output logic [DW-1:0]        o_rd_data
);

   logic          w_in_range;
   logic          w_is_zero;
   logic [DW-1:0] w_data;

   always_comb begin
      w_in_range = int'(i_rd_addr) < DEPTH;
      w_is_zero  = (ZERO_REG != 0) && (int'(i_rd_addr) == REG_ZERO_ADDR);
      w_data     = '0;
      if (w_in_range)
         w_data = i_mem_flat[slice_lo(int'(i_rd_addr), DW) +: DW];
      // Later port overrides earlier, so write port 1 has bypass priority.
      if (BYPASS != 0) begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (i_wr_en[j] && (i_wr_addr[slice_lo(j, AW) +: AW] == i_rd_addr))
               w_data = i_wr_data[slice_lo(j, DW) +: DW];
         end
      end
      if (!w_in_range || w_is_zero || !i_clr_n)
         w_data = '0;
   end

   assign o_rd_data = w_data;

endmodule

// File: rtl/reg_file_mp.sv
// Dual-write, NUM_RD-read register file with bypass, zero register and async
// clear; REGFILE_SCOREBOARD_EN adds the REG_busy pending-write scoreboard.
module reg_file_mp
   import regfile_pkg::*;
#(
   parameter int DW       = DEF_DW,
   parameter int AW       = DEF_AW,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic         SYS_clk,
   input  logic         SYS_reset_n,
   reg_file_mp_if.slave reg_if
);

   logic [DW-1:0]       r_mem [DEPTH];
   logic [AW-1:0]       w_wa [NUM_WR];
   logic [DW-1:0]       w_wd [NUM_WR];
   logic [NUM_WR-1:0]   w_we_ok;
   logic [DEPTH*DW-1:0] w_mem_flat;
   logic [DW-1:0]       w_rd_data [NUM_RD];

   // A write lands only if it targets a real, writable register.
   always_comb begin
      for (int j = 0; j < NUM_WR; j++) begin
         w_wa[j]    = reg_if.REG_wr_addr[slice_lo(j, AW) +: AW];
         w_wd[j]    = reg_if.REG_wr_data[slice_lo(j, DW) +: DW];
         w_we_ok[j] = reg_if.REG_wr_en[j] && (int'(w_wa[j]) < DEPTH) &&
                      !((ZERO_REG != 0) && (int'(w_wa[j]) == REG_ZERO_ADDR));
      end
   end

   always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else begin
         if (w_we_ok[WR_P0]) r_mem[w_wa[WR_P0]] <= w_wd[WR_P0];
         if (w_we_ok[WR_P1]) r_mem[w_wa[WR_P1]] <= w_wd[WR_P1];
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_flat
      assign w_mem_flat[i*DW +: DW] = r_mem[i];
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      reg_file_rd_port #(
         .DW       (DW),
         .AW       (AW),
         .DEPTH    (DEPTH),
         .BYPASS   (BYPASS),
         .ZERO_REG (ZERO_REG)
      ) u_rd_port (
         .i_clr_n    (SYS_reset_n),
         .i_rd_addr  (reg_if.REG_rd_addr[p*AW +: AW]),
         .i_mem_flat (w_mem_flat),
         .i_wr_en    (reg_if.REG_wr_en),
         .i_wr_addr  (reg_if.REG_wr_addr),
         .i_wr_data  (reg_if.REG_wr_data),
         .o_rd_data  (w_rd_data[p])
      );
      assign reg_if.REG_rd_data[p*DW +: DW] = w_rd_data[p];
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_nxt;

   // Clear on any enabled write first, then a new set wins on the same bit.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int a = 0; a < DEPTH; a++) begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (reg_if.REG_wr_en[j] && (int'(w_wa[j]) == a))
               w_busy_nxt[a] = 1'b0;
         end
         if (reg_if.REG_busy_set && (int'(reg_if.REG_busy_addr) == a) &&
             !((ZERO_REG != 0) && (a == REG_ZERO_ADDR)))
            w_busy_nxt[a] = 1'b1;
      end
   end

   always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) r_busy <= '0;
      else              r_busy <= w_busy_nxt;
   end

   assign reg_if.REG_busy = r_busy;
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (DEPTH=40, three read ports); the
// scoreboard checks are built only with REGFILE_SCOREBOARD_EN.
module tb_reg_file_mp;

   localparam int DW     = 32;
   localparam int AW     = 6;
   localparam int DEPTH  = 40;
   localparam int NUM_RD = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_file_mp_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) bus ();

   reg_file_mp #(
      .DW(DW), .AW(AW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .BYPASS(1), .ZERO_REG(1)
   ) dut (
      .SYS_clk     (clk),
      .SYS_reset_n (rst_n),
      .reg_if      (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0]  en;
      int          a0;
      logic [31:0] d0;
      int          a1;
      logic [31:0] d1;
      int          r0, r1, r2;
      logic [31:0] e0, e1, e2;
   } vec_t;

   vec_t tbl [10];

   logic [31:0]      m_mem [64];
   logic [DEPTH-1:0] m_busy;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_wr(input logic [1:0] en, input int a0, input logic [31:0] d0,
                         input int a1, input logic [31:0] d1);
      bus.REG_wr_en   = en;
      bus.REG_wr_addr = {AW'(a1), AW'(a0)};
      bus.REG_wr_data = {d1, d0};
   endtask

   task automatic set_rd(input int r0, input int r1, input int r2);
      bus.REG_rd_addr = {AW'(r2), AW'(r1), AW'(r0)};
   endtask

   function automatic logic [31:0] rd(input int p);
      return bus.REG_rd_data[p*DW +: DW];
   endfunction

   function automatic int rnd_addr();
      if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 3));
      return int'($urandom_range(0, 47));
   endfunction

   // Expected read this cycle: zero/out-of-range give 0, else newest write wins.
   function automatic logic [31:0] model_rd(input int a, input logic [1:0] en,
                                            input int a0, input logic [31:0] d0,
                                            input int a1, input logic [31:0] d1);
      if (a == 0 || a >= DEPTH) return 32'd0;
      if (en[1] && a1 == a) return d1;
      if (en[0] && a0 == a) return d0;
      return m_mem[a];
   endfunction

   initial begin
      tbl[0] = '{2'b01,  8, 32'd12,        0, 32'd0,          8,  9, 10, 32'd12,        32'd0,         32'd0};
      tbl[1] = '{2'b00,  0, 32'd0,         0, 32'd0,          8,  9, 10, 32'd12,        32'd0,         32'd0};
      tbl[2] = '{2'b11,  9, 32'hAAAA_0001, 10, 32'h5555_0002, 9, 10,  8, 32'hAAAA_0001, 32'h5555_0002, 32'd12};
      tbl[3] = '{2'b00,  0, 32'd0,         0, 32'd0,          9, 10,  8, 32'hAAAA_0001, 32'h5555_0002, 32'd12};
      tbl[4] = '{2'b11,  5, 32'd1,         5, 32'd2,          5,  5,  9, 32'd2,         32'd2,         32'hAAAA_0001};
      tbl[5] = '{2'b00,  0, 32'd0,         0, 32'd0,          5,  0, 45, 32'd2,         32'd0,         32'd0};
      tbl[6] = '{2'b11,  0, 32'hFFFF_FFFF, 45, 32'hFFFF_FFFF, 0, 45,  5, 32'd0,         32'd0,         32'd2};
      tbl[7] = '{2'b00,  0, 32'd0,         0, 32'd0,          0, 45, 39, 32'd0,         32'd0,         32'd0};
      tbl[8] = '{2'b11, 39, 32'hDEAD_BEEF, 40, 32'h1234_5678, 39, 40,  0, 32'hDEAD_BEEF, 32'd0,         32'd0};
      tbl[9] = '{2'b00,  0, 32'd0,         0, 32'd0,         39, 40, 63, 32'hDEAD_BEEF, 32'd0,         32'd0};

      set_wr(2'b00, 0, 0, 0, 0);
      set_rd(8, 9, 10);
`ifdef REGFILE_SCOREBOARD_EN
      bus.REG_busy_set  = 1'b0;
      bus.REG_busy_addr = '0;
`endif

      // Reset held two cycles; a write attempted under reset must not land or forward.
      @(negedge clk);
      set_wr(2'b11, 8, 32'hFFFF_FFFF, 9, 32'hFFFF_FFFF);
      #1;
      check("rst_rd0", rd(0), 0);
      check("rst_rd1", rd(1), 0);
      check("rst_rd2", rd(2), 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      set_wr(2'b00, 0, 0, 0, 0);
      #1;
      check("rst_drop_r8", rd(0), 0);
      check("rst_drop_r9", rd(1), 0);
`ifdef REGFILE_SCOREBOARD_EN
      check("sb_rst", 64'(bus.REG_busy), 0);
`endif

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         set_wr(tbl[i].en, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1);
         set_rd(tbl[i].r0, tbl[i].r1, tbl[i].r2);
         #1;
         check($sformatf("tbl%0d_p0", i), rd(0), tbl[i].e0);
         check($sformatf("tbl%0d_p1", i), rd(1), tbl[i].e1);
         check($sformatf("tbl%0d_p2", i), rd(2), tbl[i].e2);
      end

      // Asynchronous clear between edges.
      @(negedge clk);
      set_wr(2'b01, 3, 32'd7, 0, 0);
      set_rd(3, 8, 39);
      @(negedge clk);
      set_wr(2'b00, 0, 0, 0, 0);
      #1;
      check("async_pre_r3", rd(0), 32'd7);
      rst_n = 1'b0;
      #1;
      check("async_clr_r3", rd(0), 0);
      check("async_clr_r8", rd(1), 0);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("async_post_r3", rd(0), 0);
      check("async_post_r8", rd(1), 0);
      check("async_post_r39", rd(2), 0);

`ifdef REGFILE_SCOREBOARD_EN
      @(negedge clk);
      bus.REG_busy_set = 1'b1; bus.REG_busy_addr = AW'(4);
      @(negedge clk);
      bus.REG_busy_set = 1'b0;
      #1;
      check("sb_set_r4", 64'(bus.REG_busy[4]), 1);
      set_wr(2'b10, 0, 0, 4, 32'd44);
      @(negedge clk);
      set_wr(2'b00, 0, 0, 0, 0);
      #1;
      check("sb_clr_r4", 64'(bus.REG_busy[4]), 0);
      bus.REG_busy_set = 1'b1; bus.REG_busy_addr = AW'(4);
      set_wr(2'b01, 4, 32'd45, 0, 0);
      @(negedge clk);
      bus.REG_busy_set = 1'b0;
      set_wr(2'b00, 0, 0, 0, 0);
      #1;
      check("sb_setclr_r4", 64'(bus.REG_busy[4]), 1);
      bus.REG_busy_set = 1'b1; bus.REG_busy_addr = AW'(0);
      @(negedge clk);
      bus.REG_busy_addr = AW'(45);
      #1;
      check("sb_set_r0", 64'(bus.REG_busy[0]), 0);
      @(negedge clk);
      bus.REG_busy_set = 1'b0;
      #1;
      check("sb_vec", 64'(bus.REG_busy), 64'h10);
`endif

      // Randomised phase from a fresh reset against the reference model.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
      m_busy = '0;

      for (int it = 0; it < 400; it++) begin
         logic [1:0]  en;
         int          a0, a1, sa;
         logic [31:0] d0, d1;
         int          ra [3];
         logic        bs;
         @(negedge clk);
`ifdef REGFILE_SCOREBOARD_EN
         check("rnd_busy", 64'(bus.REG_busy), 64'(m_busy));
`endif
         en = 2'($urandom_range(0, 3));
         a0 = rnd_addr();
         a1 = rnd_addr();
         d0 = $urandom();
         d1 = $urandom();
         for (int p = 0; p < 3; p++) ra[p] = rnd_addr();
         bs = ($urandom_range(0, 2) == 0);
         sa = rnd_addr();
         set_wr(en, a0, d0, a1, d1);
         set_rd(ra[0], ra[1], ra[2]);
`ifdef REGFILE_SCOREBOARD_EN
         bus.REG_busy_set  = bs;
         bus.REG_busy_addr = AW'(sa);
`endif
         #1;
         for (int p = 0; p < 3; p++)
            check($sformatf("rnd%0d_p%0d_a%0d", it, p, ra[p]), rd(p),
                  model_rd(ra[p], en, a0, d0, a1, d1));
         if (en[0] && a0 != 0 && a0 < DEPTH) m_mem[a0] = d0;
         if (en[1] && a1 != 0 && a1 < DEPTH) m_mem[a1] = d1;
         for (int a = 0; a < DEPTH; a++) begin
            if ((en[0] && a0 == a) || (en[1] && a1 == a)) m_busy[a] = 1'b0;
            if (bs && sa == a && a != 0) m_busy[a] = 1'b1;
         end
      end
      @(negedge clk);
      set_wr(2'b00, 0, 0, 0, 0);
`ifdef REGFILE_SCOREBOARD_EN
      bus.REG_busy_set = 1'b0;
      check("rnd_busy_final", 64'(bus.REG_busy), 64'(m_busy));
`endif
      set_rd(1, 2, 3);
      #1;
      for (int p = 0; p < 3; p++)
         check($sformatf("final_r%0d", p + 1), rd(p), m_mem[p + 1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the MIPS datapath; successor to the single-write, dual-read register file.
- Generalised in data width, depth and read-port count.
- Adds a second write port for dual write-back, write-to-read bypass, a hardwired zero register and asynchronous clear.
- Sits between decode (reads) and write-back (writes).

Parameters:
- DW, 32, data width in bits
- AW, 6, address width in bits
- DEPTH, 64, number of registers; must be ≤ 2^AW
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes

Ports:
- SYS_clk  input  1  system clock, rising edge
- SYS_reset_n  input  1  asynchronous active-low reset
- REG_rd_addr  input  NUM_RD*AW  read addresses; port i at bits [i*AW +: AW]
- REG_rd_data  output  NUM_RD*DW  read data; port i at bits [i*DW +: DW]
- REG_wr_en  input  2  per write-port enable
- REG_wr_addr  input  2*AW  write addresses; port j at bits [j*AW +: AW]
- REG_wr_data  input  2*DW  write data; port j at bits [j*DW +: DW]
- REG_busy_set  input  1  scoreboard: mark REG_busy_addr pending (REGFILE_SCOREBOARD_EN only)
- REG_busy_addr  input  AW  scoreboard address (REGFILE_SCOREBOARD_EN only)
- REG_busy  output  DEPTH  per-register pending bits (REGFILE_SCOREBOARD_EN only)

Behaviour:
- Reset: SYS_reset_n low clears every register to 0 immediately, without waiting for a clock edge. All REG_rd_data read 0 while reset is low. Reset asserted mid-write drops that write.
- Write: on the rising SYS_clk edge, each port j with REG_wr_en[j]=1 stores REG_wr_data[j] at REG_wr_addr[j]. Write latency is 1 cycle.
- Write conflict: both ports enabled to the same address → port 1 wins; port 0 data is discarded.
- Read: combinational, 0-cycle latency, from array contents.
- Bypass (BYPASS=1): a read whose address matches an enabled write this cycle returns the write data, with port 1 taking priority over port 0. With BYPASS=0 the read returns the old array value until after the edge.
- Zero register (ZERO_REG=1): address 0 always reads 0, including when bypassed. Writes to address 0 are ignored.
- Out of range (address ≥ DEPTH): reads return 0; writes are ignored.
- All read ports are independent; any number may read the same address.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- When defined:
  - REG_busy is a DEPTH-bit register, cleared by reset.
  - REG_busy_set=1 sets bit REG_busy_addr at the next edge.
  - Any enabled write to address a clears bit a at the same edge.
  - Set and clear on the same address in the same cycle → bit ends 1 (new producer wins).
  - Bit 0 is never set when ZERO_REG=1; out-of-range set requests are ignored.
- When undefined: REG_busy_set, REG_busy_addr and REG_busy are absent and no scoreboard logic is built.

Decomposition:
- Shared package regfile_pkg holds:
  - default DW/AW/DEPTH constants
  - REG_ZERO_ADDR = 0
  - a function for flattened-slice index computation
- One sub-module is natural: reg_file_rd_port, a single read mux with bypass compare and zero/out-of-range masking, instantiated NUM_RD times in a generate loop.

Test Plan:
- Reset/basic write-read: hold SYS_reset_n=0 for 2 cycles, then write 32'd12 to r8 via port 0 → r8 reads 32'd12 on the cycle after the edge; r9 and r10 read 0.
- Dual write: port 0 writes r9=32'hAAAA_0001 and port 1 writes r10=32'h5555_0002 in one cycle → next cycle read port 0 (r9)=32'hAAAA_0001 and read port 1 (r10)=32'h5555_0002.
- Conflict and bypass: both ports write r5, port 0=32'd1 and port 1=32'd2, while a read of r5 is active → same cycle with BYPASS=1 read=2; after the edge r5=2.
- Zero/out-of-range (DEPTH=40): write 32'hFFFF_FFFF to r0 and r45 → both read 0; r0 read=0 even during the bypass cycle.
- Async reset mid-op: load r3=32'd7, then pulse SYS_reset_n low for 3 ns between clock edges → r3 reads 0 immediately, with no clock edge required.
- Scoreboard (REGFILE_SCOREBOARD_EN): set r4 busy → REG_busy[4]=1 next cycle. Write r4 → bit clears. Set and write r4 in the same cycle → bit stays 1. Set r0 → REG_busy[0] stays 0.
